// File: rtl/peripheral_bus_pkg.sv
// peripheral_bus_pkg
//   Shared definitions for the peripheral bus arbiter and its watchdog:
//   arbiter state encoding, fixed data/byte-lane widths and default
//   parameter values for address width and watchdog timeout.
package peripheral_bus_pkg;

  localparam int PERIPHERAL_DATA_WIDTH  = 32;
  localparam int PERIPHERAL_SEL_WIDTH   = 4;
  localparam int DEFAULT_ADDR_WIDTH     = 24;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/peripheral_bus_watchdog.sv
// peripheral_bus_watchdog
//   Busy-cycle counter used to abort hung peripheral transactions.
//   Only instantiated when PERIPHERAL_ARB_TIMEOUT_EN is defined.
// Ports:
//   i_clk       clock
//   i_rst       synchronous active-high reset
//   i_clear     hold the count at zero (arbiter not in a transaction)
//   i_count_en  count one busy cycle
//   o_expired   count has reached TIMEOUT_CYCLES
module peripheral_bus_watchdog
  import peripheral_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int              CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  // Saturates at LIMIT so the counter can never wrap while busy persists.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_count_en && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// peripheral_bus_arbiter
//   Round-robin arbiter and transaction sequencer for the shared 24-bit
//   peripheral bus. Requester 0 is the Wishbone bridge, requester 1 a second
//   master (e.g. DMA). The grant is held until the peripheral drops busy,
//   the owner withdraws its request, or (optionally) the watchdog expires.
// Configuration:
//   PERIPHERAL_ARB_TIMEOUT_EN  when defined, a watchdog aborts a transaction
//                              after TIMEOUT_CYCLES busy cycles and pulses
//                              m*_error with m*_done. Otherwise ACTIVE waits
//                              indefinitely and m*_error are tied to 0.
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   m{0,1}_req/we/address/
//     byteSelect/dataWrite        requester transaction inputs
//   m{0,1}_grant/done/error/
//     dataRead                    requester responses
//   peripheralBus_*               shared peripheral bus
module peripheral_bus_arbiter
  import peripheral_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             m0_req,
  input  logic                             m0_we,
  input  logic [ADDR_WIDTH-1:0]            m0_address,
  input  logic [PERIPHERAL_SEL_WIDTH-1:0]  m0_byteSelect,
  input  logic [PERIPHERAL_DATA_WIDTH-1:0] m0_dataWrite,
  output logic                             m0_grant,
  output logic                             m0_done,
  output logic                             m0_error,
  output logic [PERIPHERAL_DATA_WIDTH-1:0] m0_dataRead,
  input  logic                             m1_req,
  input  logic                             m1_we,
  input  logic [ADDR_WIDTH-1:0]            m1_address,
  input  logic [PERIPHERAL_SEL_WIDTH-1:0]  m1_byteSelect,
  input  logic [PERIPHERAL_DATA_WIDTH-1:0] m1_dataWrite,
  output logic                             m1_grant,
  output logic                             m1_done,
  output logic                             m1_error,
  output logic [PERIPHERAL_DATA_WIDTH-1:0] m1_dataRead,
  output logic                             peripheralBus_we,
  output logic                             peripheralBus_oe,
  input  logic                             peripheralBus_busy,
  output logic [ADDR_WIDTH-1:0]            peripheralBus_address,
  output logic [PERIPHERAL_SEL_WIDTH-1:0]  peripheralBus_byteSelect,
  output logic [PERIPHERAL_DATA_WIDTH-1:0] peripheralBus_dataWrite,
  input  logic [PERIPHERAL_DATA_WIDTH-1:0] peripheralBus_dataRead
);

  arb_state_t r_state;
  logic       r_owner;
  logic       r_lastOwner;

  logic                             w_active;
  logic                             w_ownReq;
  logic                             w_ownWe;
  logic [ADDR_WIDTH-1:0]            w_ownAddr;
  logic [PERIPHERAL_SEL_WIDTH-1:0]  w_ownSel;
  logic [PERIPHERAL_DATA_WIDTH-1:0] w_ownData;
  logic                             w_timeout;
  logic                             w_complete;
  logic                             w_xferOn;
  logic                             w_done;
  logic                             w_end;
  logic [PERIPHERAL_DATA_WIDTH-1:0] w_readData;

  assign w_active  = (r_state == ST_ACTIVE);
  assign w_ownReq  = r_owner ? m1_req        : m0_req;
  assign w_ownWe   = r_owner ? m1_we         : m0_we;
  assign w_ownAddr = r_owner ? m1_address    : m0_address;
  assign w_ownSel  = r_owner ? m1_byteSelect : m0_byteSelect;
  assign w_ownData = r_owner ? m1_dataWrite  : m0_dataWrite;

`ifdef PERIPHERAL_ARB_TIMEOUT_EN
  logic w_expired;

  // Counter is held clear in IDLE, so it starts from zero on every entry
  // to ACTIVE (IDLE always separates transactions).
  peripheral_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_clear    (!w_active),
    .i_count_en (w_active && peripheralBus_busy),
    .o_expired  (w_expired)
  );

  assign w_timeout = w_active && w_ownReq && peripheralBus_busy && w_expired;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
`endif

  // Normal completion: owner still requesting and the peripheral is ready.
  assign w_complete = w_active && w_ownReq && !peripheralBus_busy;
  // Strobes only while the owner holds its request and no abort is in force.
  assign w_xferOn   = w_active && w_ownReq && !w_timeout;
  assign w_done     = w_complete || w_timeout;
  // Any of: completion, request withdrawn, watchdog abort.
  assign w_end      = w_active && (!w_ownReq || !peripheralBus_busy || w_timeout);
  assign w_readData = (w_complete && !w_ownWe) ? peripheralBus_dataRead : '0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_owner     <= 1'b0;
      r_lastOwner <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            r_state <= ST_ACTIVE;
            if (m0_req && m1_req) begin
              r_owner <= ~r_lastOwner;
            end else begin
              r_owner <= m1_req;
            end
          end
        end
        ST_ACTIVE: begin
          if (w_end) begin
            r_state     <= ST_IDLE;
            r_lastOwner <= r_owner;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    m0_grant                 = w_active && !r_owner;
    m1_grant                 = w_active &&  r_owner;
    m0_done                  = w_done && !r_owner;
    m1_done                  = w_done &&  r_owner;
    m0_error                 = w_timeout && !r_owner;
    m1_error                 = w_timeout &&  r_owner;
    m0_dataRead              = r_owner ? '0 : w_readData;
    m1_dataRead              = r_owner ? w_readData : '0;
    peripheralBus_we         = w_xferOn &&  w_ownWe;
    peripheralBus_oe         = w_xferOn && !w_ownWe;
    peripheralBus_address    = w_active ? w_ownAddr : '0;
    peripheralBus_byteSelect = w_active ? w_ownSel  : '0;
    peripheralBus_dataWrite  = w_active ? w_ownData : '0;
  end

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// tb_peripheral_bus_arbiter
//   Directed vector table for the arbitration/latency corner cases, a
//   hand-written watchdog (or no-watchdog) sequence, then randomized traffic
//   checked every cycle against a transaction-level reference model.
module tb_peripheral_bus_arbiter;

  localparam int AW  = 24;
  localparam int TMO = 8;
`ifdef PERIPHERAL_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [31:0] DB = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_address, m1_address;
  logic [3:0]  m0_byteSelect, m1_byteSelect;
  logic [31:0] m0_dataWrite, m1_dataWrite;
  logic        m0_grant, m0_done, m0_error, m1_grant, m1_done, m1_error;
  logic [31:0] m0_dataRead, m1_dataRead;
  logic        pb_we, pb_oe, pb_busy;
  logic [AW-1:0] pb_address;
  logic [3:0]  pb_byteSelect;
  logic [31:0] pb_dataWrite, pb_dataRead;

  always #5 clk = ~clk;

  peripheral_bus_arbiter #(
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_address(m0_address),
    .m0_byteSelect(m0_byteSelect), .m0_dataWrite(m0_dataWrite),
    .m0_grant(m0_grant), .m0_done(m0_done), .m0_error(m0_error),
    .m0_dataRead(m0_dataRead),
    .m1_req(m1_req), .m1_we(m1_we), .m1_address(m1_address),
    .m1_byteSelect(m1_byteSelect), .m1_dataWrite(m1_dataWrite),
    .m1_grant(m1_grant), .m1_done(m1_done), .m1_error(m1_error),
    .m1_dataRead(m1_dataRead),
    .peripheralBus_we(pb_we), .peripheralBus_oe(pb_oe),
    .peripheralBus_busy(pb_busy), .peripheralBus_address(pb_address),
    .peripheralBus_byteSelect(pb_byteSelect),
    .peripheralBus_dataWrite(pb_dataWrite),
    .peripheralBus_dataRead(pb_dataRead)
  );

  typedef struct {
    logic g0, g1, d0, d1, e0, e1, we, oe;
    logic [AW-1:0] addr;
    logic [3:0]  bs;
    logic [31:0] dw, rd0, rd1;
  } out_t;

  typedef struct {
    logic rst, r0, w0, r1, w1, busy;
    logic g0, g1, d0, d1, e0, e1, we, oe;
    logic [31:0] rd0, rd1;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  // Reference model: owner is -1 when the bus is free.
  int mOwner = -1;
  int mLast  = 1;
  int mCnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic out_t model_expect();
    out_t e;
    logic oreq, owe;
    e = '{default: '0};
    if (mOwner >= 0) begin
      oreq   = (mOwner == 1) ? m1_req        : m0_req;
      owe    = (mOwner == 1) ? m1_we         : m0_we;
      e.addr = (mOwner == 1) ? m1_address    : m0_address;
      e.bs   = (mOwner == 1) ? m1_byteSelect : m0_byteSelect;
      e.dw   = (mOwner == 1) ? m1_dataWrite  : m0_dataWrite;
      if (mOwner == 1) e.g1 = 1'b1; else e.g0 = 1'b1;
      if (oreq) begin
        if (TMO_EN && pb_busy && mCnt >= TMO) begin
          if (mOwner == 1) begin e.d1 = 1'b1; e.e1 = 1'b1; end
          else             begin e.d0 = 1'b1; e.e0 = 1'b1; end
        end else begin
          e.we = owe;
          e.oe = !owe;
          if (!pb_busy) begin
            if (mOwner == 1) begin e.d1 = 1'b1; e.rd1 = owe ? 32'h0 : pb_dataRead; end
            else             begin e.d0 = 1'b1; e.rd0 = owe ? 32'h0 : pb_dataRead; end
          end
        end
      end
    end
    return e;
  endfunction

  task automatic model_step();
    logic oreq;
    if (rst) begin
      mOwner = -1; mLast = 1; mCnt = 0;
    end else if (mOwner < 0) begin
      mCnt = 0;
      if (m0_req && m1_req) mOwner = 1 - mLast;
      else if (m0_req)      mOwner = 0;
      else if (m1_req)      mOwner = 1;
    end else begin
      oreq = (mOwner == 1) ? m1_req : m0_req;
      if (!oreq || !pb_busy || (TMO_EN && mCnt >= TMO)) begin
        mLast  = mOwner;
        mOwner = -1;
      end else begin
        mCnt++;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    out_t e;
    e = model_expect();
    chk({tag, ".m0_grant"}, m0_grant, e.g0);
    chk({tag, ".m1_grant"}, m1_grant, e.g1);
    chk({tag, ".m0_done"},  m0_done,  e.d0);
    chk({tag, ".m1_done"},  m1_done,  e.d1);
    chk({tag, ".m0_error"}, m0_error, e.e0);
    chk({tag, ".m1_error"}, m1_error, e.e1);
    chk({tag, ".bus_we"},   pb_we,    e.we);
    chk({tag, ".bus_oe"},   pb_oe,    e.oe);
    chk({tag, ".bus_addr"}, pb_address, e.addr);
    chk({tag, ".bus_sel"},  pb_byteSelect, e.bs);
    chk({tag, ".bus_wdat"}, pb_dataWrite, e.dw);
    chk({tag, ".m0_rdat"},  m0_dataRead, e.rd0);
    chk({tag, ".m1_rdat"},  m1_dataRead, e.rd1);
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; m0_req = v.r0; m0_we = v.w0;
    m1_req = v.r1; m1_we = v.w1; pb_busy = v.busy;
  endtask

  // Inputs are already driven; sample at negedge, then advance past posedge.
  task automatic run_cycle(input bit useModel, input bit useTab, input vec_t v, input string tag);
    @(negedge clk);
    if (useModel) compare_model(tag);
    if (useTab) begin
      chk({tag, ".tab_m0_grant"}, m0_grant, v.g0);
      chk({tag, ".tab_m1_grant"}, m1_grant, v.g1);
      chk({tag, ".tab_m0_done"},  m0_done,  v.d0);
      chk({tag, ".tab_m1_done"},  m1_done,  v.d1);
      chk({tag, ".tab_m0_error"}, m0_error, v.e0);
      chk({tag, ".tab_m1_error"}, m1_error, v.e1);
      chk({tag, ".tab_bus_we"},   pb_we,    v.we);
      chk({tag, ".tab_bus_oe"},   pb_oe,    v.oe);
      chk({tag, ".tab_m0_rdat"},  m0_dataRead, v.rd0);
      chk({tag, ".tab_m1_rdat"},  m1_dataRead, v.rd1);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic vec_t mk(input logic rs, r0, w0, r1, w1, bsy,
                              input logic g0, g1, d0, d1, e0, e1, we, oe,
                              input logic [31:0] rd0, rd1);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.busy = bsy;
    v.g0 = g0; v.g1 = g1; v.d0 = d0; v.d1 = d1; v.e0 = e0; v.e1 = e1;
    v.we = we; v.oe = oe; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  vec_t tab[$];
  vec_t v;

  initial begin
    rst = 1'b1; m0_req = 1'b0; m0_we = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    m0_address = 24'h000010; m0_byteSelect = 4'hF; m0_dataWrite = 32'hA5A5A5A5;
    m1_address = 24'h000020; m1_byteSelect = 4'hF; m1_dataWrite = 32'h12345678;
    pb_busy = 1'b0; pb_dataRead = DB;

    //            rst r0 w0 r1 w1 bsy  g0 g1 d0 d1 e0 e1 we oe  rd0 rd1
    tab.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0));  // reset state
    tab.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0));  // m0 read sampled
    tab.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 1, DB, 0));  // 1-cycle latency
    tab.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0));  // reset: lastOwner=1
    tab.push_back(mk(0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0));  // contention
    tab.push_back(mk(0, 1, 0, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0, 1, DB, 0));  // m0 first
    tab.push_back(mk(0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0));
    tab.push_back(mk(0, 1, 0, 1, 0, 0,  0, 1, 0, 1, 0, 0, 0, 1, 0,  DB)); // m1 two cycles later
    tab.push_back(mk(0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0));
    tab.push_back(mk(0, 1, 0, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0, 1, DB, 0));  // alternates back
    tab.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0));
    tab.push_back(mk(0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0));  // m1 write
    for (int i = 0; i < 5; i++)
      tab.push_back(mk(0, 0, 0, 1, 1, 1,  0, 1, 0, 0, 0, 0, 1, 0, 0,  0)); // busy 5 cycles
    tab.push_back(mk(0, 0, 0, 1, 1, 0,  0, 1, 0, 1, 0, 0, 1, 0, 0,  0));  // done on 6th, rd=0
    tab.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0));
    tab.push_back(mk(0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0));
    tab.push_back(mk(0, 1, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 1, 0,  0));
    tab.push_back(mk(1, 1, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 1, 0,  0));  // reset mid-ACTIVE
    tab.push_back(mk(0, 1, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0));  // dropped silently
    tab.push_back(mk(0, 1, 0, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0, 1, DB, 0));  // m0 wins post-reset
    tab.push_back(mk(0, 1, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0));
    tab.push_back(mk(0, 1, 0, 1, 0, 1,  0, 1, 0, 0, 0, 0, 0, 1, 0,  0));  // m1 owns, busy
    tab.push_back(mk(0, 1, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0, 0, 0,  0));  // m1 drops: abort
    tab.push_back(mk(0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0));
    tab.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 1, DB, 0));  // m0 served next
    tab.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0));

    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(v); run_cycle(0, 0, v, "init");
    apply(v); run_cycle(0, 0, v, "init");

    foreach (tab[i]) begin
      apply(tab[i]);
      run_cycle(1, 1, tab[i], $sformatf("tab%0d", i));
    end

    v = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(v); run_cycle(1, 1, v, "seq_rst");
`ifdef PERIPHERAL_ARB_TIMEOUT_EN
    v = mk(0, 1, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(v); run_cycle(1, 1, v, "tmo_idle");
    for (int i = 1; i <= TMO; i++) begin
      v = mk(0, 1, 0, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      apply(v); run_cycle(1, 1, v, $sformatf("tmo_busy%0d", i));
    end
    v = mk(0, 1, 0, 1, 0, 1,  1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    apply(v); run_cycle(1, 1, v, "tmo_abort");
    v = mk(0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(v); run_cycle(1, 1, v, "tmo_after");
    v = mk(0, 0, 0, 1, 0, 1,  0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    apply(v); run_cycle(1, 1, v, "tmo_m1_grant");
    v = mk(0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 0, 0, 0, 1, 0, DB);
    apply(v); run_cycle(1, 1, v, "tmo_m1_done");
`else
    v = mk(0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(v); run_cycle(1, 1, v, "hang_idle");
    for (int i = 1; i <= 20; i++) begin
      v = mk(0, 1, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      apply(v); run_cycle(1, 1, v, $sformatf("hang_busy%0d", i));
    end
    v = mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 1, DB, 0);
    apply(v); run_cycle(1, 1, v, "hang_done");
`endif
    v = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(v); run_cycle(1, 1, v, "seq_end");

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!m0_req) begin
        m0_req = ($urandom_range(0, 2) == 0);
        m0_we = $urandom_range(0, 1) != 0;
        m0_address = AW'($urandom); m0_byteSelect = 4'($urandom);
        m0_dataWrite = $urandom;
      end else if ($urandom_range(0, 5) == 0) begin
        m0_req = 1'b0;
      end
      if (!m1_req) begin
        m1_req = ($urandom_range(0, 2) == 0);
        m1_we = $urandom_range(0, 1) != 0;
        m1_address = AW'($urandom); m1_byteSelect = 4'($urandom);
        m1_dataWrite = $urandom;
      end else if ($urandom_range(0, 5) == 0) begin
        m1_req = 1'b0;
      end
      pb_busy = ($urandom_range(0, 2) != 0);
      pb_dataRead = $urandom;
      run_cycle(1, 0, v, $sformatf("rand%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
